// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, one-entry skid buffer and IF/ID register.
// Optional macro FETCH_HALT_EN adds a HALT state entered on opcode 4'hF.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic [15:0] pc
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {FETCH, DROP, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, DROP} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic        r_started;
  logic [15:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [15:0] r_tgt, w_tgt_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic [15:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [15:0] r_ifid_pc, w_ifid_pc_nxt;
  logic [15:0] r_ifid_pc2, w_ifid_pc2_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;
  logic [15:0] r_skid_instr, w_skid_instr_nxt;
  logic [15:0] r_skid_pc, w_skid_pc_nxt;
  logic        w_req;
  logic        w_take;

  // Request stays up in DROP so the abandoned transfer can still complete.
  assign w_req  = r_started && ((r_state == FETCH && !r_skid_valid) || r_state == DROP);
  assign w_take = w_req && imem_ready && (r_state == FETCH) && !redirect_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_tgt_nxt        = r_tgt;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_pc2_nxt   = r_ifid_pc2;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;

    case (r_state)
      FETCH: begin
        if (redirect_valid) begin
          if (w_req && !imem_ready) begin
            w_state_nxt = DROP;
            w_tgt_nxt   = redirect_pc;
          end else begin
            w_fetch_pc_nxt = redirect_pc;
          end
        end else if (w_take) begin
          w_fetch_pc_nxt = r_fetch_pc + 16'd2;
`ifdef FETCH_HALT_EN
          if (imem_data[15:12] == 4'hF) w_state_nxt = HALT;
`endif
        end
      end
      DROP: begin
        if (redirect_valid) w_tgt_nxt = redirect_pc;
        if (imem_ready) begin
          w_state_nxt    = FETCH;
          w_fetch_pc_nxt = redirect_valid ? redirect_pc : r_tgt;
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        if (redirect_valid) begin
          w_state_nxt    = FETCH;
          w_fetch_pc_nxt = redirect_pc;
        end
      end
`endif
      default: w_state_nxt = FETCH;
    endcase

    // IF/ID and skid movement; redirect flushes both regardless of stall.
    if (redirect_valid || r_state == DROP) begin
      w_ifid_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_ifid_valid || !stall) begin
      if (r_skid_valid) begin
        w_ifid_valid_nxt = 1'b1;
        w_ifid_instr_nxt = r_skid_instr;
        w_ifid_pc_nxt    = r_skid_pc;
        w_ifid_pc2_nxt   = r_skid_pc + 16'd2;
        w_skid_valid_nxt = w_take;
        w_skid_instr_nxt = imem_data;
        w_skid_pc_nxt    = r_fetch_pc;
      end else if (w_take) begin
        w_ifid_valid_nxt = 1'b1;
        w_ifid_instr_nxt = imem_data;
        w_ifid_pc_nxt    = r_fetch_pc;
        w_ifid_pc2_nxt   = r_fetch_pc + 16'd2;
      end else begin
        w_ifid_valid_nxt = 1'b0;
      end
    end else if (w_take) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_instr_nxt = imem_data;
      w_skid_pc_nxt    = r_fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_started    <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_tgt        <= RESET_PC;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= 16'h0000;
      r_ifid_pc    <= 16'h0000;
      r_ifid_pc2   <= 16'h0000;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 16'h0000;
      r_skid_pc    <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_started    <= 1'b1;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_tgt        <= w_tgt_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_pc2   <= w_ifid_pc2_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  assign imem_req      = w_req;
  assign imem_addr     = r_fetch_pc;
  assign ifid_valid    = r_ifid_valid;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus2 = r_ifid_pc2;
  assign pc            = r_ifid_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/skid, bubbles, redirect/DROP, wrap, async reset.
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic [15:0] pc;
  logic        f_en;
  int          nvec;
  int          nerr;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: opcode 2 plus low address bits, with an optional 4'hF word at 0006.
  always_comb begin
    imem_data = {4'h2, imem_addr[11:0]};
    if (f_en && imem_addr == 16'h0006) imem_data = 16'hF000;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_ready = 1'b1; f_en = 1'b0;
    step(); step();
    chk("rst_req", {15'd0, imem_req}, 16'h0000);
    chk("rst_valid", {15'd0, ifid_valid}, 16'h0000);
    chk("rst_instr", ifid_instr, 16'h0000);
    chk("rst_pc2", ifid_pc_plus2, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("rel_req_low", {15'd0, imem_req}, 16'h0000);

    // Sequential fetch with single-cycle memory
    step();
    chk("seq_req", {15'd0, imem_req}, 16'h0001);
    chk("seq_addr0", imem_addr, 16'h0000);
    step();
    chk("seq_addr1", imem_addr, 16'h0002);
    chk("seq_pc2_0", ifid_pc_plus2, 16'h0002);
    chk("seq_instr0", ifid_instr, 16'h2000);
    chk("seq_valid", {15'd0, ifid_valid}, 16'h0001);
    step();
    chk("seq_addr2", imem_addr, 16'h0004);
    chk("seq_pc2_1", ifid_pc_plus2, 16'h0004);
    step();
    chk("seq_pc2_2", ifid_pc2_sel(), 16'h0006);
    chk("seq_instr2", ifid_instr, 16'h2004);

    // Stall three cycles: next word parks in the skid, request drops
    stall = 1'b1;
    step();
    chk("stl_req", {15'd0, imem_req}, 16'h0000);
    chk("stl_pc2_a", ifid_pc_plus2, 16'h0006);
    step(); step();
    chk("stl_pc2_c", ifid_pc_plus2, 16'h0006);
    chk("stl_instr_c", ifid_instr, 16'h2004);
    chk("stl_req_c", {15'd0, imem_req}, 16'h0000);
    stall = 1'b0;
    step();
    chk("unstl_skid_instr", ifid_instr, 16'h2006);
    chk("unstl_skid_pc2", ifid_pc_plus2, 16'h0008);
    chk("unstl_req", {15'd0, imem_req}, 16'h0001);
    chk("unstl_addr", imem_addr, 16'h0008);
    step();
    chk("unstl_mem_instr", ifid_instr, 16'h2008);
    chk("unstl_mem_pc2", ifid_pc_plus2, 16'h000A);

    // Memory not ready: bubble, request held
    imem_ready = 1'b0;
    step();
    chk("bub_valid", {15'd0, ifid_valid}, 16'h0000);
    chk("bub_addr", imem_addr, 16'h000A);
    chk("bub_req", {15'd0, imem_req}, 16'h0001);

    // Redirect in second wait cycle -> DROP
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    chk("drop_addr_held", imem_addr, 16'h000A);
    chk("drop_req_held", {15'd0, imem_req}, 16'h0001);
    chk("drop_valid", {15'd0, ifid_valid}, 16'h0000);
    imem_ready = 1'b1;
    step();
    chk("drop_new_addr", imem_addr, 16'h0100);
    chk("drop_discard", {15'd0, ifid_valid}, 16'h0000);
    imem_ready = 1'b0;
    step();
    chk("drop_wait_valid", {15'd0, ifid_valid}, 16'h0000);
    imem_ready = 1'b1;
    step();
    chk("drop_ret_instr", ifid_instr, 16'h2100);
    chk("drop_ret_pc2", ifid_pc_plus2, 16'h0102);

    // Two redirects during DROP: latest target wins
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect_pc = 16'h0300;
    step();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    step();
    chk("latest_addr", imem_addr, 16'h0300);
    chk("latest_valid", {15'd0, ifid_valid}, 16'h0000);
    step();
    chk("latest_instr", ifid_instr, 16'h2300);

    // Redirect with ready and stall in the same cycle
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    chk("rdst_valid", {15'd0, ifid_valid}, 16'h0000);
    chk("rdst_addr", imem_addr, 16'h0040);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    chk("rdst_instr", ifid_instr, 16'h2040);
    chk("rdst_pc2", ifid_pc_plus2, 16'h0042);

    // PC wrap FFFE -> 0000
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr_a", imem_addr, 16'hFFFE);
    step();
    chk("wrap_addr_b", imem_addr, 16'h0000);
    chk("wrap_pc2", ifid_pc_plus2, 16'h0000);
    chk("wrap_pc", pc, 16'hFFFE);
    chk("wrap_instr", ifid_instr, 16'h2FFE);

    // Opcode F at 0006
    f_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0004;
    step();
    redirect_valid = 1'b0;
    step();
    chk("opf_pre_pc2", ifid_pc_plus2, 16'h0006);
    step();
    chk("opf_instr", ifid_instr, 16'hF000);
    chk("opf_pc2", ifid_pc_plus2, 16'h0008);
`ifdef FETCH_HALT_EN
    chk("halt_req", {15'd0, imem_req}, 16'h0000);
    step();
    chk("halt_req2", {15'd0, imem_req}, 16'h0000);
    chk("halt_bubble", {15'd0, ifid_valid}, 16'h0000);
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    step();
    redirect_valid = 1'b0;
    chk("halt_resume_req", {15'd0, imem_req}, 16'h0001);
    chk("halt_resume_addr", imem_addr, 16'h0000);
`else
    chk("nohalt_req", {15'd0, imem_req}, 16'h0001);
    chk("nohalt_addr", imem_addr, 16'h0008);
    step();
    chk("nohalt_pc2", ifid_pc_plus2, 16'h000A);
`endif

    // Asynchronous reset mid-request
    imem_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {15'd0, imem_req}, 16'h0000);
    chk("arst_valid", {15'd0, ifid_valid}, 16'h0000);
    chk("arst_instr", ifid_instr, 16'h0000);
    chk("arst_pc2", ifid_pc_plus2, 16'h0000);
    chk("arst_pc", pc, 16'h0000);
    chk("arst_addr", imem_addr, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  function automatic logic [15:0] ifid_pc2_sel();
    return ifid_pc_plus2;
  endfunction

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL expose parameter RESET_PC, default 16'h0000, meaning the PC loaded on reset.
REQ-002 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL expose: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL expose: stall  input  1  decode cannot accept; hold IF/ID contents.
REQ-005 SHALL expose: redirect_valid  input  1  taken branch/BR/flush from a later stage.
REQ-006 SHALL expose: redirect_pc  input  16  fetch target when redirect_valid=1.
REQ-007 SHALL expose: imem_req  output  1  instruction-memory read request.
REQ-008 SHALL expose: imem_addr  output  16  word-aligned fetch address.
REQ-009 SHALL expose: imem_ready  input  1  imem_data valid this cycle; completes the request.
REQ-010 SHALL expose: imem_data  input  16  returned instruction.
REQ-011 SHALL expose: ifid_valid  output  1  IF/ID register holds a live instruction.
REQ-012 SHALL expose: ifid_instr  output  16  instruction for decode.
REQ-013 SHALL expose: ifid_pc_plus2  output  16  fetch PC + 2 (used by B target and PCS).
REQ-014 SHALL expose: pc  output  16  PC of the instruction in IF/ID (debug/trace).

Function
REQ-015 SHALL implement states FETCH, DROP, HALT; reset enters FETCH.
REQ-016 Memory handshake: imem_req and imem_addr SHALL stay stable from assertion until the cycle imem_ready=1; a transfer completes in any cycle with imem_req=1 and imem_ready=1.
REQ-017 In FETCH, imem_req=1 unless the skid buffer is full; imem_addr=fetch_pc.
REQ-018 On completion in FETCH with no redirect: if IF/ID empty or stall=0, data SHALL load into IF/ID next cycle (ifid_pc_plus2=fetch_pc+2); else into the one-entry skid buffer; fetch_pc SHALL advance by 2, wrapping 16'hFFFE->16'h0000.
REQ-019 When stall=0 and skid full, the skid entry SHALL move to IF/ID before any newly returned data; IF/ID order SHALL equal fetch order.
REQ-020 stall=1 SHALL hold ifid_valid, ifid_instr, ifid_pc_plus2, pc unchanged.
REQ-021 stall=0 with nothing available SHALL clear ifid_valid next cycle (bubble).
REQ-022 redirect_valid=1 SHALL, next cycle, clear ifid_valid and skid, set fetch_pc=redirect_pc, and take priority over stall and any completing data.
REQ-023 Redirect while a request is outstanding and imem_ready=0 SHALL enter DROP: keep old imem_req/imem_addr until imem_ready, discard that data, then FETCH at the redirect target.
REQ-024 A second redirect while in DROP SHALL overwrite the pending target; latest wins.
REQ-025 Redirect in the same cycle as imem_ready SHALL discard the data and stay in FETCH at redirect_pc.
REQ-026 Best-case latency: request issued cycle N, imem_ready in N -> ifid_valid=1 in N+1; throughput one instruction per cycle with single-cycle memory.

Reset
REQ-027 On rst_n=0, asynchronously: state=FETCH, fetch_pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc_plus2=0, pc=0, skid empty, imem_req=0.
REQ-028 imem_req SHALL first assert the cycle after rst_n deasserts; reset mid-request SHALL abandon it with no data captured.

Configuration
REQ-029 Macro FETCH_HALT_EN: when defined, a returned instruction with opcode [15:12]=4'hF SHALL be delivered to IF/ID normally and fetch SHALL enter HALT (imem_req=0) until redirect_valid or reset.
REQ-030 Without FETCH_HALT_EN, opcode 4'hF SHALL be fetched like any other instruction and no HALT state exists.

Verification
REQ-031 Reset release, 1-cycle memory, stall=0 -> imem_addr 0000,0002,0004; ifid_pc_plus2 0002,0004,0006 on consecutive cycles.
REQ-032 stall=1 for 3 cycles with memory ready -> IF/ID unchanged, skid holds next instr, imem_req=0; stall=0 -> skid then memory data, no loss or duplication.
REQ-033 3-cycle memory latency, redirect to 16'h0100 in 2nd wait cycle -> DROP, old data discarded, next imem_addr=0100, ifid_valid=0 until it returns.
REQ-034 Redirect to 16'h0040 with imem_ready=1 and stall=1 same cycle -> ifid_valid=0 next cycle, imem_addr=0040.
REQ-035 FETCH_HALT_EN defined, instr 16'hF000 at 0006 -> delivered with ifid_pc_plus2=0008, imem_req=0 thereafter; redirect to 0000 resumes.
REQ-036 fetch_pc=FFFE -> next imem_addr=0000; rst_n low mid-request -> all outputs at reset values asynchronously.
